// File: rtl/mux_host_pkg.sv
// Shared types and constants for the host-side driver of a wrapped project.
// iw/ow bit layout matches the project's {uio, ui, rst_n, clk} / {uio_oe, uio_out, uo_out} pins.
package mux_host_pkg;

  localparam int IW_W     = 18;
  localparam int OW_W     = 24;
  localparam int CLK_BIT  = 0;
  localparam int RSTN_BIT = 1;
  localparam int UI_LSB   = 2;
  localparam int UIO_LSB  = 10;

  typedef enum logic [1:0] {
    OP_PEEK  = 2'b00,
    OP_RESET = 2'b01,
    OP_SET   = 2'b10,
    OP_STEP  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    RST_LO,
    CLK_LO,
    CLK_HI,
    CAPTURE,
    RESP
  } state_e;

  // Number of full design-clock cycles a command runs; 9 bits so STEP 255 gives 256.
  function automatic logic [8:0] cycle_target(input op_e op, input logic [7:0] count);
    logic [8:0] n;
    n = {1'b0, count};
    if (op == OP_STEP) begin
      cycle_target = n + 9'd1;
    end else begin
      cycle_target = (count == 8'd0) ? 9'd1 : n;
    end
  endfunction

endpackage

// File: rtl/mux_host_clkgen.sv
// Phase divider (CLK_DIV+1 clk per half-phase) and design-clock cycle counter.
// phase_done pulses on the last clk of each phase; cycles_done holds once the target is reached.
module mux_host_clkgen #(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [8:0] target,
  input  logic       cycle_end,
  output logic       phase_done,
  output logic       cycles_done
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV);

  logic [7:0] div_cnt;
  logic [8:0] cyc_cnt;
  logic [8:0] cyc_tgt;

  assign phase_done  = (div_cnt == DIV_LAST);
  assign cycles_done = (cyc_cnt == cyc_tgt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= 8'd0;
      cyc_cnt <= 9'd0;
      cyc_tgt <= 9'd0;
    end else begin
      // Every phase boundary restarts the divider, so phases chain back to back.
      if (load || phase_done) begin
        div_cnt <= 8'd0;
      end else begin
        div_cnt <= div_cnt + 8'd1;
      end
      if (load) begin
        cyc_cnt <= 9'd0;
        cyc_tgt <= target;
      end else if (cycle_end) begin
        cyc_cnt <= cyc_cnt + 9'd1;
      end
    end
  end

endmodule

// File: rtl/mux_host_driver.sv
// Host driver: one command at a time sets inputs, clocks/resets the project, captures ow; PEEK/SET respond 2 cycles after accept.
// Response holds until rsp_ready; cmd_ready is low while busy. MUX_HOST_PARITY_EN adds a registered rsp_parity output.
module mux_host_driver
  import mux_host_pkg::*;
#(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [15:0]     cmd_data,
  input  logic [7:0]      cmd_count,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [23:0]     rsp_data,
  output logic            ena,
  output logic [IW_W-1:0] iw,
  input  logic [OW_W-1:0] ow
`ifdef MUX_HOST_PARITY_EN
  ,
  output logic            rsp_parity
`endif
);

  state_e     state, state_nxt;
  op_e        op_in, op_q;
  logic       out_of_reset;
  logic       accept;
  logic       load, cycle_end;
  logic       phase_done, cycles_done;
  logic [15:0] data_q;
  logic       rstn_q, clk_q;

  assign op_in     = op_e'(cmd_op);
  assign cmd_ready = out_of_reset && (state == IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign rsp_valid = (state == RESP);

  mux_host_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .target      (cycle_target(op_in, cmd_count)),
    .cycle_end   (cycle_end),
    .phase_done  (phase_done),
    .cycles_done (cycles_done)
  );

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    cycle_end = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          load = 1'b1;
          case (op_in)
            OP_RESET: state_nxt = RST_LO;
            OP_STEP:  state_nxt = CLK_HI;
            default:  state_nxt = CAPTURE;
          endcase
        end
      end
      RST_LO:  if (phase_done) state_nxt = CLK_HI;
      CLK_HI: begin
        if (phase_done) begin
          cycle_end = 1'b1;
          state_nxt = CLK_LO;
        end
      end
      CLK_LO:  if (phase_done) state_nxt = cycles_done ? CAPTURE : CLK_HI;
      CAPTURE: state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      out_of_reset <= 1'b0;
      ena          <= 1'b0;
      op_q         <= OP_PEEK;
      data_q       <= 16'd0;
      rstn_q       <= 1'b0;
      clk_q        <= 1'b0;
      rsp_data     <= 24'd0;
`ifdef MUX_HOST_PARITY_EN
      rsp_parity   <= 1'b0;
`endif
    end else begin
      state        <= state_nxt;
      out_of_reset <= 1'b1;
      // clk_dut is registered from the next state so it is glitch-free and high exactly in CLK_HI.
      clk_q        <= (state_nxt == CLK_HI);
      if (accept) begin
        ena  <= 1'b1;
        op_q <= op_in;
        if (op_in == OP_SET || op_in == OP_STEP) data_q <= cmd_data;
        if (op_in == OP_RESET) rstn_q <= 1'b0;
      end
      if (state == CLK_LO && state_nxt == CAPTURE && op_q == OP_RESET) rstn_q <= 1'b1;
      if (state == CAPTURE) begin
        rsp_data <= ow;
`ifdef MUX_HOST_PARITY_EN
        rsp_parity <= ^ow;
`endif
      end
    end
  end

  always_comb begin
    iw                  = '0;
    iw[CLK_BIT]         = clk_q;
    iw[RSTN_BIT]        = rstn_q;
    iw[UI_LSB +: 8]     = data_q[7:0];
    iw[UIO_LSB +: 8]    = data_q[15:8];
  end

endmodule

// File: tb/tb_mux_host_driver.sv
// Bench for mux_host_driver: a counter-based wrapped-project model drives ow; responses are scoreboarded.
module tb_mux_host_driver;
  import mux_host_pkg::*;

  localparam int D = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_data;
  logic [7:0]  cmd_count;
  logic        rsp_valid, rsp_ready;
  logic [23:0] rsp_data;
  logic        ena;
  logic [17:0] iw;
  logic [23:0] ow;
`ifdef MUX_HOST_PARITY_EN
  logic        rsp_parity;
`endif

  mux_host_driver #(.CLK_DIV(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_count (cmd_count),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .ena       (ena),
    .iw        (iw),
    .ow        (ow)
`ifdef MUX_HOST_PARITY_EN
    ,
    .rsp_parity(rsp_parity)
`endif
  );

  always #5 clk = ~clk;

  // Wrapped project: counts clk_dut rising edges, synchronous reset from rst_n_dut.
  logic [7:0]  w_cnt = 8'd0;
  logic        ow_ovr_en = 1'b0;
  logic [23:0] ow_ovr = 24'd0;
  always @(posedge iw[0]) w_cnt <= iw[1] ? w_cnt + 8'd1 : 8'd0;
  assign ow = ow_ovr_en ? ow_ovr : {iw[17:2], w_cnt};

  // clk_dut edge monitor
  int   rises = 0, rises_lo = 0, hi_bad = 0, hi_run = 0;
  logic prev_clk = 1'b0;
  always @(negedge clk) begin
    if (iw[0] && !prev_clk) begin
      rises <= rises + 1;
      if (!iw[1]) rises_lo <= rises_lo + 1;
    end
    if (iw[0]) hi_run <= hi_run + 1;
    else begin
      if (prev_clk && hi_run != D + 1) hi_bad <= hi_bad + 1;
      hi_run <= 0;
    end
    prev_clk <= iw[0];
  end

  int          n_tests = 0, n_fail = 0;
  logic [23:0] sb[$];
  logic [15:0] m_data;
  logic [7:0]  m_cnt;
  logic        m_rstn;
  int          rise0, rlo0, hbad0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input op_e op, input logic [15:0] d, input logic [7:0] c, input bit push);
    int n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_before_issue", 32'(cmd_ready), 32'd1);
    cmd_op = op; cmd_data = d; cmd_count = c; cmd_valid = 1'b1;
    case (op)
      OP_SET:   m_data = d;
      OP_STEP: begin
        m_data = d;
        m_cnt  = m_rstn ? m_cnt + c + 8'd1 : 8'd0;
      end
      OP_RESET: begin
        m_cnt  = 8'd0;
        m_rstn = 1'b1;
      end
      default: ;
    endcase
    if (push) sb.push_back(ow_ovr_en ? ow_ovr : {m_data, m_cnt});
    rise0 = rises; rlo0 = rises_lo; hbad0 = hi_bad;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Entered on the negedge of the first cycle after acceptance.
  task automatic collect(input string tag, input int exp_lat);
    int lat = 1;
    while (!rsp_valid && lat < 3000) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_rsp_seen"}, 32'(rsp_valid), 32'd1);
    if (exp_lat > 0) check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) check({tag, "_rsp_data"}, 32'(rsp_data), 32'(sb.pop_front()));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "_rsp_consumed"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    logic [23:0] held;
    logic [7:0]  cnt_save;
    int          k;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 16'd0; cmd_count = 8'd0; rsp_ready = 1'b0;
    m_data = 16'd0; m_cnt = 8'd0; m_rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_iw", 32'(iw), 32'd0);
    check("rst_ena", 32'(ena), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

    issue(OP_RESET, 16'h0, 8'd0, 1'b1);
    collect("reset0", 0);
    check("reset0_rises", 32'(rises - rise0), 32'd1);
    check("reset0_rises_in_reset", 32'(rises_lo - rlo0), 32'd1);
    check("reset0_rstn_released", 32'(iw[1]), 32'd1);
    check("ena_set", 32'(ena), 32'd1);

    issue(OP_SET, 16'hA55A, 8'd7, 1'b1);
    collect("set", 2);
    check("set_iw", 32'(iw[17:2]), 32'hA55A);
    check("set_no_edge", 32'(rises - rise0), 32'd0);

    issue(OP_STEP, 16'h1234, 8'd3, 1'b1);
    collect("step3", 2 + 2 * 4 * (D + 1));
    check("step3_rises", 32'(rises - rise0), 32'd4);
    check("step3_hi_width", 32'(hi_bad - hbad0), 32'd0);

    issue(OP_STEP, 16'h1234, 8'd0, 1'b1);
    collect("step0", 2 + 2 * 1 * (D + 1));
    check("step0_rises", 32'(rises - rise0), 32'd1);

    issue(OP_PEEK, 16'hFFFF, 8'd0, 1'b1);
    collect("peek", 2);
    check("peek_iw_unchanged", 32'(iw[17:2]), 32'h1234);

    issue(OP_STEP, 16'h5A01, 8'd255, 1'b1);
    collect("step255", 2 + 2 * 256 * (D + 1));
    check("step255_rises", 32'(rises - rise0), 32'd256);
    check("step255_hi_width", 32'(hi_bad - hbad0), 32'd0);

    // Backpressure: response held with a second command waiting.
    issue(OP_PEEK, 16'h0, 8'd0, 1'b1);
    k = 1;
    while (!rsp_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("bp_rsp_seen", 32'(rsp_valid), 32'd1);
    held = (sb.size() != 0) ? sb.pop_front() : 24'hFFFFFF;
    check("bp_rsp_data", 32'(rsp_data), 32'(held));
    cmd_op = OP_PEEK; cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_data_stable", 32'(rsp_data), 32'(held));
      check("bp_valid_held", 32'(rsp_valid), 32'd1);
      check("bp_cmd_ready_low", 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    sb.push_back({m_data, m_cnt});
    @(negedge clk);
    rsp_ready = 1'b0;
    check("bp_ready_after_handshake", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("bp_next_accepted", 32'(cmd_ready), 32'd0);
    collect("bp_next", 2);

    // Abort a long STEP with reset in cycle 19 after acceptance.
    cnt_save = m_cnt;
    issue(OP_STEP, 16'h00F0, 8'd255, 1'b0);
    repeat (18) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_iw", 32'(iw), 32'd0);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_ena", 32'(ena), 32'd0);
    m_cnt  = cnt_save + 8'(((19 - 1) / (2 * (D + 1))) + 1);
    m_data = 16'd0;
    m_rstn = 1'b0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("abort_no_stale_rsp", 32'(rsp_valid), 32'd0);
    end
    issue(OP_PEEK, 16'h0, 8'd0, 1'b1);
    collect("abort_peek", 2);

`ifdef MUX_HOST_PARITY_EN
    ow_ovr_en = 1'b1;
    ow_ovr    = 24'h000007;
    issue(OP_PEEK, 16'h0, 8'd0, 1'b1);
    collect("parity_peek", 2);
    check("parity_bit", 32'(rsp_parity), 32'd1);
    ow_ovr_en = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
